// File: rtl/egress_port_arbiter.sv
// Frame-granular round-robin arbiter that merges four first-word-fall-through ingress FIFOs
// into one egress TX FIFO. Once a frame starts, it is forwarded whole; frames never interleave.
module egress_port_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [71:0]       in0_dout,
  input  logic [71:0]       in1_dout,
  input  logic [71:0]       in2_dout,
  input  logic [71:0]       in3_dout,
  input  logic [NREQ-1:0]   in_empty,
  output logic [NREQ-1:0]   in_rd_en,
  output logic [71:0]       out_din,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [1:0]         grant_q,     grant_d;
  logic               in_frame_q,  in_frame_d;
  logic [71:0]        out_din_q,   out_din_d;
  logic               out_wr_en_q, out_wr_en_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic [71:0]        head_s;
  logic               found_s;
  logic [1:0]         next_grant_s;
  logic               pop_s;

  // A control byte of all ones marks an idle word or a frame terminator.
  function automatic logic is_ctrl_word(input logic [71:0] w);
    return (w[71:64] == 8'hff);
  endfunction

  // Head word of the currently granted ingress FIFO.
  always_comb begin
    head_s = 72'd0;
    case (grant_q)
      2'd0:    head_s = in0_dout;
      2'd1:    head_s = in1_dout;
      2'd2:    head_s = in2_dout;
      default: head_s = in3_dout;
    endcase
  end

  // Round-robin search starting one past the last grant, wrapping back to it.
  always_comb begin
    logic [1:0] cand;
    found_s      = 1'b0;
    next_grant_s = grant_q;
    cand         = grant_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand         = grant_q + 2'(k);
      next_grant_s = (!found_s && !in_empty[cand]) ? cand : next_grant_s;
      found_s      = found_s | !in_empty[cand];
    end
  end

  // Next-state, pop decision and egress word selection.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    in_frame_d  = in_frame_q;
    out_din_d   = out_din_q;
    out_wr_en_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d    = next_grant_s;
          in_frame_d = 1'b0;
          state_d    = ST_XFER;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_XFER: begin
        pop_s = ~in_empty[grant_q] & ~out_full;
        if (pop_s) begin
          if (!is_ctrl_word(head_s)) begin
            out_din_d   = head_s;
            out_wr_en_d = 1'b1;
            in_frame_d  = 1'b1;
          end else if (in_frame_q) begin
            // Terminator: grant is left in place and becomes the round-robin pointer.
            out_din_d   = head_s;
            out_wr_en_d = 1'b1;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            in_frame_d  = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            // Leading idle word ahead of a frame: consumed and dropped.
            out_wr_en_d = 1'b0;
          end
        end else begin
          out_wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'd3;
      in_frame_q  <= 1'b0;
      out_din_q   <= 72'd0;
      out_wr_en_q <= 1'b0;
      frame_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      in_frame_q  <= in_frame_d;
      out_din_q   <= out_din_d;
      out_wr_en_q <= out_wr_en_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_rd_en  = pop_s ? (NREQ'(1) << grant_q) : {NREQ{1'b0}};
  assign out_din   = out_din_q;
  assign out_wr_en = out_wr_en_q;
  assign grant     = grant_q;
  assign busy      = (state_q == ST_XFER);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_egress_port_arbiter.sv
// Scoreboard bench for egress_port_arbiter: the bench owns the ingress FIFO contents, a frame-level
// round-robin model predicts the egress stream, and a negedge monitor compares every egress write.
module tb_egress_port_arbiter;

  typedef logic [71:0] word_t;
  typedef struct {
    word_t       w;
    logic [1:0]  src;
    logic [15:0] fcnt;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  word_t       in_dout [4];
  logic [3:0]  in_empty;
  logic [3:0]  in_rd_en;
  logic [71:0] out_din;
  logic        out_full;
  logic        out_wr_en;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] frame_cnt;

  word_t       fq [4][$];
  exp_t        expq [$];
  int          nvec = 0;
  int          nmis = 0;
  int          mp;
  logic [15:0] mfcnt;
  logic [3:0]  gate;
  logic [3:0]  force_gate;
  logic        force_full;
  int          full_pct;
  int          gate_pct;
  int          wr_count = 0;

  egress_port_arbiter #(.NREQ(4), .CNT_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in0_dout  (in_dout[0]),
    .in1_dout  (in_dout[1]),
    .in2_dout  (in_dout[2]),
    .in3_dout  (in_dout[3]),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_din   (out_din),
    .out_full  (out_full),
    .out_wr_en (out_wr_en),
    .grant     (grant),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic bit fq_nonempty();
    return (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) > 0;
  endfunction

  task automatic drive_inputs();
    for (int n = 0; n < 4; n++) begin
      in_empty[n] = (fq[n].size() == 0) | gate[n];
      in_dout[n]  = (fq[n].size() > 0) ? fq[n][0] : 72'd0;
    end
  endtask

  task automatic add_frame(input int n, input int nidle, input int ndata);
    word_t w;
    for (int i = 0; i < nidle; i++) begin
      w = {8'hff, $urandom, $urandom};
      fq[n].push_back(w);
    end
    for (int i = 0; i < ndata; i++) begin
      w = {8'($urandom_range(0, 254)), $urandom, $urandom};
      fq[n].push_back(w);
    end
    w = {8'hff, $urandom, $urandom};
    fq[n].push_back(w);
  endtask

  // Reference: whole frames, round-robin from one past the last served FIFO.
  task automatic model_load();
    word_t mq [4][$];
    word_t w;
    int    f;
    exp_t  e;
    for (int n = 0; n < 4; n++) mq[n] = fq[n];
    forever begin
      f = -1;
      for (int k = 1; k <= 4; k++)
        if (f < 0 && mq[(mp + k) % 4].size() > 0) f = (mp + k) % 4;
      if (f < 0) break;
      while (mq[f].size() > 0) begin
        w = mq[f][0];
        if (w[71:64] != 8'hff) break;
        void'(mq[f].pop_front());
      end
      while (mq[f].size() > 0) begin
        w = mq[f].pop_front();
        if (w[71:64] == 8'hff) mfcnt = mfcnt + 16'd1;
        e.w = w; e.src = 2'(f); e.fcnt = mfcnt;
        expq.push_back(e);
        if (w[71:64] == 8'hff) break;
      end
      mp = f;
    end
  endtask

  // One clock: sample pops before the edge, apply them and new stimulus just after it.
  task automatic cycle();
    logic [3:0] rd;
    @(negedge sys_clk);
    rd = in_rd_en;
    @(posedge sys_clk);
    #1;
    for (int n = 0; n < 4; n++)
      if (rd[n] && fq[n].size() > 0) void'(fq[n].pop_front());
    out_full = force_full | ($urandom_range(0, 99) < full_pct);
    for (int n = 0; n < 4; n++)
      gate[n] = force_gate[n] | (busy && grant == 2'(n) && $urandom_range(0, 99) < gate_pct);
    drive_inputs();
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((expq.size() > 0 || busy || fq_nonempty()) && c < 3000) begin
      cycle();
      c++;
    end
    check({name, "_drained"}, {71'd0, (expq.size() == 0 && !fq_nonempty())}, 72'd1);
  endtask

  // Scoreboard monitor.
  always @(negedge sys_clk) begin
    exp_t e;
    logic legal;
    if (sys_rst_n === 1'b1) begin
      legal = ((in_rd_en & in_empty) == 4'd0) && ($countones(in_rd_en) <= 1) &&
              !(out_full && in_rd_en != 4'd0);
      check("rd_en_legal", {71'd0, legal}, 72'd1);
      if (out_wr_en) begin
        wr_count++;
        if (expq.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_write: got %h expected no write", out_din);
        end else begin
          e = expq.pop_front();
          check("out_din", out_din, e.w);
          check("grant_src", {70'd0, grant}, {70'd0, e.src});
          check("frame_cnt", {56'd0, frame_cnt}, {56'd0, e.fcnt});
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] pat;
    int          wc0;
    logic [15:0] fc0;
    sys_rst_n  = 1'b0;
    out_full   = 1'b0;
    gate       = 4'd0;
    force_gate = 4'd0;
    force_full = 1'b0;
    full_pct   = 0;
    gate_pct   = 0;
    mp         = 3;
    mfcnt      = 16'd0;
    drive_inputs();
    #22;
    check("rst_grant", {70'd0, grant}, 72'd3);
    check("rst_outs", {in_rd_en, out_wr_en, busy, frame_cnt}, 72'd0);
    check("rst_din", out_din, 72'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cycle();
    cycle();

    // 3 data words + terminator on FIFO 0 straight after reset
    add_frame(0, 0, 3);
    drive_inputs();
    model_load();
    cycle();
    check("t1_arb", {grant, busy, out_wr_en}, {68'd0, 2'd0, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t1_wr_run", {71'd0, out_wr_en}, 72'd1);
    end
    cycle();
    check("t1_end", {frame_cnt, grant, busy, out_wr_en}, {52'd0, 16'd1, 2'd0, 1'b0, 1'b0});
    drain("t1");

    // park the pointer on 3, then one 2-word frame per FIFO
    add_frame(3, 0, 1);
    drive_inputs();
    model_load();
    drain("t2pre");
    for (int n = 0; n < 4; n++) add_frame(n, 0, 1);
    drive_inputs();
    model_load();
    for (int i = 0; i < 13; i++) begin
      cycle();
      pat[12 - i] = out_wr_en;
    end
    check("t2_wr_pattern", {59'd0, pat}, {59'd0, 13'b0110110110110});
    drain("t2");
    check("t2_frame_cnt", {56'd0, frame_cnt}, {56'd0, 16'd6});

    // pointer at 1 with FIFOs 0 and 2 pending: 2 first, then 0
    add_frame(1, 0, 2);
    drive_inputs();
    model_load();
    drain("t3pre");
    check("t3_grant1", {70'd0, grant}, 72'd1);
    add_frame(0, 0, 2);
    add_frame(2, 0, 2);
    drive_inputs();
    model_load();
    cycle();
    check("t3_first", {70'd0, grant}, 72'd2);
    drain("t3");
    check("t3_last", {70'd0, grant}, 72'd0);

    // two leading idle words are swallowed
    wc0 = wr_count;
    fc0 = mfcnt;
    add_frame(1, 2, 1);
    drive_inputs();
    model_load();
    drain("t4");
    check("t4_writes", 72'(wr_count - wc0), 72'd2);
    check("t4_frame_cnt", {56'd0, frame_cnt}, {56'd0, fc0 + 16'd1});

    // 5 back-pressure cycles mid-frame, then an empty gap on the granted FIFO
    add_frame(2, 0, 6);
    add_frame(3, 0, 1);
    drive_inputs();
    model_load();
    cycle();
    cycle();
    cycle();
    force_full = 1'b1;
    out_full   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_no_pop_full", {68'd0, in_rd_en}, 72'd0);
      if (i == 4) force_full = 1'b0;
      cycle();
    end
    force_gate = 4'b0100;
    gate[2]    = 1'b1;
    drive_inputs();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t5_locked", {69'd0, grant, busy}, {69'd0, 2'd2, 1'b1});
      cycle();
    end
    force_gate = 4'd0;
    drain("t5");

    // randomized frames, stalls and empty gaps
    full_pct = 30;
    gate_pct = 30;
    for (int r = 0; r < 20; r++) begin
      for (int n = 0; n < 4; n++)
        if ($urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, 3)) add_frame(n, $urandom_range(0, 2), $urandom_range(1, 5));
      drive_inputs();
      model_load();
      drain("rand");
    end
    full_pct = 0;
    gate_pct = 0;
    out_full = 1'b0;
    gate     = 4'd0;
    drive_inputs();
    cycle();

    // asynchronous reset in the middle of a frame
    add_frame(0, 0, 5);
    add_frame(1, 0, 2);
    drive_inputs();
    model_load();
    cycle();
    cycle();
    cycle();
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_grant", {70'd0, grant}, 72'd3);
    check("t6_rst_outs", {in_rd_en, out_wr_en, busy, frame_cnt}, 72'd0);
    check("t6_rst_din", out_din, 72'd0);
    expq.delete();
    for (int n = 0; n < 4; n++) fq[n].delete();
    gate  = 4'd0;
    mp    = 3;
    mfcnt = 16'd0;
    drive_inputs();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cycle();
    add_frame(1, 0, 1);
    add_frame(0, 0, 1);
    drive_inputs();
    model_load();
    cycle();
    check("t6_restart_grant", {70'd0, grant}, 72'd0);
    drain("t6");
    check("t6_frame_cnt", {56'd0, frame_cnt}, 72'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/egress_port_arbiter.md
Name: egress_port_arbiter

Overview:
Frame-granular round-robin arbiter that merges four per-ingress 72-bit frame FIFOs into one egress TX FIFO.
Each forwarder instance writes to its portN FIFO. For one egress port, those four FIFOs are the requesters here. The block moves whole frames only; words from different frames never interleave at the egress.
Word format: bits [71:64] are the control byte. Value 8'hff marks a non-data word, which is an idle word or a frame terminator. Bits [63:0] are payload.

Parameters:
NREQ, 4, number of ingress FIFOs; fixed at 4 in this revision.
CNT_W, 16, width of the egress frame counter.

Ports:
sys_clk  in  1  system clock; all logic on the rising edge.
sys_rst_n  in  1  reset; asynchronous assert, active-low.
in0_dout..in3_dout  in  72 each  head word of ingress FIFO n. These are first-word-fall-through FIFOs: the word is valid whenever in_empty[n]=0.
in_empty  in  4  ingress FIFO empty flags, bit n belongs to FIFO n.
in_rd_en  out  4  pop strobes, bit n belongs to FIFO n. Combinational; at most one bit is high.
out_din  out  72  registered egress word.
out_full  in  1  egress almost-full. Must assert with at least 1 free entry left.
out_wr_en  out  1  registered egress write strobe.
grant  out  2  index of the currently or last granted requester.
busy  out  1  high in XFER state.
frame_cnt  out  CNT_W  count of frames completed to the egress; wraps.

Behaviour:
- Reset values: in_rd_en=0, out_din=0, out_wr_en=0, grant=2'd3, busy=0, frame_cnt=0, in_frame=0, state=IDLE. Because grant resets to 3, FIFO 0 has first priority.
- States are IDLE and XFER.
- IDLE:
  - Scan requesters grant+1, grant+2, grant+3, grant+4, all mod 4. Pick the first one with in_empty=0.
  - If one is found: load grant with it, clear in_frame, go to XFER. That costs one arbitration cycle with no pop.
  - If none is found: stay in IDLE; grant holds.
- XFER, pop condition: pop = ~in_empty[grant] & ~out_full. in_rd_en[grant] = pop, and all other bits are 0.
- XFER, when pop=1 with head word w:
  - w[71:64]!=8'hff: out_din<=w, out_wr_en<=1, in_frame<=1.
  - w[71:64]==8'hff and in_frame=1: this is the terminator. out_din<=w, out_wr_en<=1, frame_cnt<=frame_cnt+1, in_frame<=0, state<=IDLE. grant holds, so it becomes the round-robin pointer.
  - w[71:64]==8'hff and in_frame=0: this is a leading idle word. Discard it: it is popped, out_wr_en=0, state stays XFER.
- XFER, stall cases (pop=0):
  - in_empty or out_full: no pop, out_wr_en<=0, state holds, and the frame stays locked to grant.
  - Mid-frame empty waits indefinitely; there is no timeout.
- Latency: a popped word appears on out_din/out_wr_en on the next cycle. Maximum throughput is 1 word/clk within a frame, plus 1 idle cycle per frame for arbitration.
- out_full slack: out_full is sampled in the pop cycle, so the write lands one cycle later. The egress FIFO must guarantee 1 entry of slack after asserting out_full.
- Simultaneous events: if out_full and in_empty are both high, no pop. A requester whose empty flag drops on the same cycle IDLE samples it is not seen until the next cycle.
- frame_cnt wraps from all-ones to 0.
- Reset mid-frame: all state clears immediately. The partial frame in the egress FIFO is not terminated; flushing it is the egress MAC's job.
- No combinational path from out_din to in_dout except through registers. in_rd_en depends only on state, grant, in_empty and out_full.

Test Plan:
- After reset, FIFO 0 holds a 3-data-word frame (ctrl 00) plus terminator (ctrl ff). Required: 1 arbitration cycle, then 4 consecutive out_wr_en pulses with the words in order, frame_cnt=1, grant=0, return to IDLE.
- All four FIFOs hold one 2-word frame each. Required: egress order FIFO 0,1,2,3 with no interleaving, frame_cnt=4, and exactly one idle cycle between frames.
- With grant=1 and FIFOs 0 and 2 both pending, the next grant is 2, then 0.
- FIFO 1 head holds two idle ff words, then a 1-data-word frame. Required: both idle words popped with no out_wr_en, then 2 writes (data, terminator), frame_cnt+1.
- Mid-frame, assert out_full for 5 cycles. Required: in_rd_en=0 for those 5 cycles, no word lost or duplicated, and the frame resumes in order. Also assert in_empty[grant] mid-frame while another FIFO is non-empty: no grant change until the terminator.
- Assert sys_rst_n low asynchronously mid-frame. Required: all outputs are 0 and grant=3 immediately without waiting for a clock edge; after release, arbitration restarts at FIFO 0.
